// File: rtl/sd_ctrl_pkg.sv
// rtl/sd_ctrl_pkg.sv - shared constants and types for the SD-card control output port
package sd_ctrl_pkg;

    // Word addresses of the register map
    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_STATUS     = 3'd1;
    localparam logic [2:0] ADDR_PULSE_MASK = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd6;

    // STATUS register bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_IRQ_BIT  = 1;

    // Pulse timer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/sd_ctrl_out_if.sv
// rtl/sd_ctrl_out_if.sv - Avalon-MM slave bus bundle for the control output port
interface sd_ctrl_out_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/sd_pulse_timer.sv
// rtl/sd_pulse_timer.sv - loadable down-counter and FSM timing the output pulse
module sd_pulse_timer
    import sd_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             done_o
);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: a load always wins, so a reload hides a same-cycle completion
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_PULSE;
                    count_d = len_i;
                end
            end
            ST_PULSE: begin
                if (load_i) begin
                    count_d = len_i;
                end else if (abort_i) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    done_o  = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign busy_o      = (state_q == ST_PULSE);
    assign remaining_o = count_q;

endmodule

// File: rtl/sd_ctrl_out.sv
// rtl/sd_ctrl_out.sv - SD-card control output port with set/clear, timed pulse and irq
module sd_ctrl_out
    import sd_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    sd_ctrl_out_if.slave      bus,
    output logic [WIDTH-1:0]  out_port,
    output logic              irq
);

    logic [WIDTH-1:0] out_reg_q, out_reg_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_pend_q, irq_pend_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [CNT_W-1:0] len;
    logic             len_wr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic             unused_wd;

    assign wr_en     = bus.chipselect && !bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign len       = bus.writedata[CNT_W-1:0];
    assign len_wr    = wr_en && (bus.address == ADDR_PULSE_LEN);
    assign unused_wd = ^bus.writedata;

    sd_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (len_wr && (len != '0)),
        .len_i       (len),
        .abort_i     (len_wr && (len == '0)),
        .busy_o      (busy),
        .remaining_o (remaining),
        .done_o      (done)
    );

    // Register writes; completion setting irq_pend overrides a STATUS clear
    always_comb begin
        out_reg_d  = out_reg_q;
        mask_d     = mask_q;
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:       out_reg_d  = wd;
                ADDR_STATUS:     irq_pend_d = 1'b0;
                ADDR_PULSE_MASK: mask_d     = wd;
                ADDR_OUTSET:     out_reg_d  = out_reg_q | wd;
                ADDR_OUTCLR:     out_reg_d  = out_reg_q & ~wd;
                ADDR_IRQ_EN:     irq_en_d   = bus.writedata[0];
                default:         ;
            endcase
        end
        if (done) begin
            irq_pend_d = 1'b1;
        end
        out_port_d = busy ? (out_reg_d ^ mask_d) : out_reg_d;
    end

    // Read mux, sampled every clock from the current address
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:       readdata_d[WIDTH-1:0] = out_reg_q;
            ADDR_STATUS: begin
                readdata_d[STATUS_BUSY_BIT] = busy;
                readdata_d[STATUS_IRQ_BIT]  = irq_pend_q;
            end
            ADDR_PULSE_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_PULSE_LEN:  readdata_d[CNT_W-1:0] = remaining;
            ADDR_IRQ_EN:     readdata_d[0]         = irq_en_q;
            default:         ;
        endcase
    end

    // Register file, output pins and read data, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg_q  <= RESET_VALUE;
            mask_q     <= '0;
            out_port_q <= RESET_VALUE;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            out_reg_q  <= out_reg_d;
            mask_q     <= mask_d;
            out_port_q <= out_port_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port     = out_port_q;
    assign irq          = irq_pend_q & irq_en_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_sd_ctrl_out.sv
// tb/tb_sd_ctrl_out.sv - scoreboard bench for sd_ctrl_out
module tb_sd_ctrl_out;

    localparam int         WIDTH = 2;
    localparam logic [1:0] RV    = 2'b01;
    localparam int         CNT_W = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] out_port;
    logic       irq;

    sd_ctrl_out_if bus_if();

    sd_ctrl_out #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] rd;
        logic        irq;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   total = 0;
    int   bad   = 0;

    // Reference model: the pulse is a window of edges (start, m_end] in absolute edge count
    longint      e = 0;
    longint      m_end = 0;
    logic [1:0]  m_out, m_mask, m_port;
    logic        m_en, m_pend;
    logic [31:0] m_rd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_out = RV; m_mask = '0; m_en = 1'b0; m_pend = 1'b0;
        m_end = 0; m_rd = '0; m_port = RV;
    endfunction

    function automatic void model_edge(bit wr, logic [2:0] a, logic [31:0] d);
        bit         was;
        bit         lenwr;
        logic [15:0] n;
        exp_t       x;
        e++;
        if (!reset_n) begin
            model_reset();
        end else begin
            was = (e - 1 < m_end);
            case (a)
                3'd0:    m_rd = {30'b0, m_out};
                3'd1:    m_rd = {30'b0, m_pend, was};
                3'd2:    m_rd = {30'b0, m_mask};
                3'd3:    m_rd = was ? 32'(m_end - (e - 1)) : 32'd0;
                3'd6:    m_rd = {31'b0, m_en};
                default: m_rd = 32'd0;
            endcase
            lenwr = wr && (a == 3'd3);
            if (wr) begin
                case (a)
                    3'd0: m_out = d[1:0];
                    3'd1: m_pend = 1'b0;
                    3'd2: m_mask = d[1:0];
                    3'd3: begin
                        n = d[15:0];
                        if (n != 0) m_end = e + longint'(n);
                        else if (was) m_end = e;
                    end
                    3'd4: m_out = m_out | d[1:0];
                    3'd5: m_out = m_out & ~d[1:0];
                    3'd6: m_en = d[0];
                    default: ;
                endcase
            end
            if (was && e >= m_end && !lenwr) m_pend = 1'b1;
            m_port = was ? (m_out ^ m_mask) : m_out;
        end
        x.port = m_port;
        x.rd   = m_rd;
        x.irq  = m_pend & m_en;
        x.id   = int'(e);
        sb_q.push_back(x);
    endfunction

    task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d);
        if (wr) begin
            bus_if.chipselect = 1'b1;
            bus_if.write_n    = 1'b0;
        end else begin
            case ($urandom_range(0, 2))
                0:       begin bus_if.chipselect = 1'b0; bus_if.write_n = 1'b0; end
                1:       begin bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; end
                default: begin bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; end
            endcase
        end
        bus_if.address   = a;
        bus_if.writedata = d;
        @(posedge clk);
        model_edge(wr, a, d);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, a, $urandom);
    endtask

    task automatic reset_now();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_port", 32'(out_port), 32'(RV));
        chk("async_rst_rdata", bus_if.readdata, 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
    endtask

    // Monitor: every sampled cycle pops one expectation and compares all outputs
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            chk($sformatf("out_port[%0d]", mon_x.id), 32'(out_port), 32'(mon_x.port));
            chk($sformatf("readdata[%0d]", mon_x.id), bus_if.readdata, mon_x.rd);
            chk($sformatf("irq[%0d]", mon_x.id), 32'(irq), 32'(mon_x.irq));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ra;
        logic [31:0] rdv;
        bus_if.address = '0; bus_if.chipselect = 1'b0;
        bus_if.write_n = 1'b1; bus_if.writedata = '0;
        model_reset();

        for (int i = 0; i < 3; i++) rd(3'd0);
        reset_n = 1'b1;
        rd(3'd0); rd(3'd1);

        wr(3'd0, 32'h2); wr(3'd4, 32'h1); wr(3'd5, 32'h2);
        rd(3'd4); rd(3'd5); rd(3'd7); wr(3'd7, 32'hFFFF_FFFF); rd(3'd0);

        wr(3'd2, 32'h1); wr(3'd0, 32'h0); wr(3'd6, 32'h1); wr(3'd3, 32'h5);
        for (int i = 0; i < 8; i++) rd(3'd1);
        wr(3'd1, 32'h0); rd(3'd1); rd(3'd1);

        wr(3'd3, 32'd10);
        for (int i = 0; i < 3; i++) rd(3'd3);
        wr(3'd3, 32'd3);
        for (int i = 0; i < 6; i++) rd(3'd3);
        wr(3'd1, 32'h0);

        wr(3'd3, 32'd8); rd(3'd1); wr(3'd3, 32'd0);
        rd(3'd1); rd(3'd1); rd(3'd3);

        wr(3'd2, 32'h3); wr(3'd3, 32'hABCD_0064);
        for (int i = 0; i < 5; i++) rd(3'd3);
        reset_now();
        rd(3'd3); rd(3'd2);
        reset_n = 1'b1;
        rd(3'd2); wr(3'd2, 32'h3); wr(3'd3, 32'h1);
        for (int i = 0; i < 3; i++) rd(3'd1);

        wr(3'd3, 32'hFFFF); rd(3'd3); rd(3'd3); wr(3'd3, 32'h0); rd(3'd1);

        wr(3'd6, 32'h1); wr(3'd3, 32'd2); rd(3'd1); wr(3'd1, 32'h0); rd(3'd1); rd(3'd1);
        wr(3'd1, 32'h0); wr(3'd3, 32'd2); rd(3'd1); wr(3'd3, 32'd4);
        for (int i = 0; i < 6; i++) rd(3'd1);

        for (int i = 0; i < 400; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rdv = $urandom;
            if (ra == 3'd3) rdv = (rdv & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) rd(ra);
            else wr(ra, rdv);
        end

        rd(3'd0); rd(3'd1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
